// File: rtl/mdm_uart_loopback_fifo_if.sv
// rtl/mdm_uart_loopback_fifo_if.sv - byte stream handshake bundle for the loopback core
interface mdm_uart_loopback_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mdm_uart_loopback_fifo.sv
// rtl/mdm_uart_loopback_fifo.sv - buffered mode-selectable RX->TX loopback with stats and activity LED
module mdm_uart_loopback_fifo #(
    parameter int                  DATA_WIDTH   = 8,
    parameter int                  FIFO_DEPTH   = 16,
    parameter logic [DATA_WIDTH-1:0] FLUSH_CHAR = 8'h0D,
    parameter int                  DROP_ON_FULL = 1,
    parameter int                  CNT_WIDTH    = 16,
    parameter int                  LED_HOLD     = 5000000
) (
    input  logic                          clk,
    input  logic                          rst,
    mdm_uart_loopback_fifo_if.slave       s_axis,
    mdm_uart_loopback_fifo_if.master      m_axis,
    input  logic [1:0]                    mode,
    input  logic                          clr_stats,
    output logic [CNT_WIDTH-1:0]          rx_count,
    output logic [CNT_WIDTH-1:0]          tx_count,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          led
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(LED_HOLD + 1);
    localparam logic [1:0] MODE_CASE = 2'd1;
    localparam logic [1:0] MODE_LINE = 2'd2;
    localparam logic [1:0] MODE_SINK = 2'd3;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr, eol_cnt;
    logic                  hold;
    logic [TW-1:0]         led_timer;
    logic                  full, empty, gate, push, pop, store, drop, eol_inc, eol_dec;
    logic [DATA_WIDTH-1:0] wdata;

    function automatic logic [DATA_WIDTH-1:0] xform(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [1:0] m);
        logic is_alpha;
        is_alpha = (d >= DATA_WIDTH'('h41) && d <= DATA_WIDTH'('h5A)) ||
                   (d >= DATA_WIDTH'('h61) && d <= DATA_WIDTH'('h7A));
        return (m == MODE_CASE && is_alpha) ? (d ^ DATA_WIDTH'('h20)) : d;
    endfunction

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign fifo_level = wr_ptr - rd_ptr;

    assign s_axis.tready = (DROP_ON_FULL != 0) ? 1'b1 : !full;
    // A full FIFO always releases, otherwise a line longer than the FIFO would deadlock.
    assign gate  = (mode != MODE_LINE) || (eol_cnt != '0) || full;
    assign m_axis.tvalid = !empty && (gate || hold);
    assign m_axis.tdata  = mem[rd_ptr[AW-1:0]];

    assign push  = s_axis.tvalid && s_axis.tready;
    assign pop   = m_axis.tvalid && m_axis.tready;
    assign wdata = xform(s_axis.tdata, mode);
    assign store = push && (mode != MODE_SINK) && (!full || pop);
    assign drop  = push && (mode != MODE_SINK) && full && !pop;
    assign eol_inc = store && (wdata == FLUSH_CHAR);
    assign eol_dec = pop && (m_axis.tdata == FLUSH_CHAR);
    assign led   = (led_timer != '0);

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            eol_cnt   <= '0;
            hold      <= 1'b0;
            led_timer <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (eol_inc && !eol_dec)      eol_cnt <= eol_cnt + (AW+1)'(1);
            else if (eol_dec && !eol_inc) eol_cnt <= eol_cnt - (AW+1)'(1);
            // Keeps a presented byte on the bus across mode changes until taken.
            if (pop)                                hold <= 1'b0;
            else if (m_axis.tvalid && !m_axis.tready) hold <= 1'b1;
            if (push || pop)          led_timer <= TW'(LED_HOLD);
            else if (led_timer != '0) led_timer <= led_timer - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_count   <= '0;
            tx_count   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clr_stats) begin
            rx_count   <= '0;
            tx_count   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push && rx_count != '1)   rx_count   <= rx_count + CNT_WIDTH'(1);
            if (pop && tx_count != '1)    tx_count   <= tx_count + CNT_WIDTH'(1);
            if (drop && drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
            if (drop)                     overflow   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mdm_uart_loopback_fifo.sv
// tb/tb_mdm_uart_loopback_fifo.sv - randomized and directed bench with a queue-based reference model
module tb_mdm_uart_loopback_fifo;
    localparam int DEPTH    = 16;
    localparam int CNT_W    = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int LED_HOLD = 8;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] mode;
    logic clr_stats;
    logic [CNT_W-1:0] rx_count, tx_count, drop_count;
    logic overflow, led;
    logic [$clog2(DEPTH):0] fifo_level;

    mdm_uart_loopback_fifo_if #(.DATA_WIDTH(8)) s_if ();
    mdm_uart_loopback_fifo_if #(.DATA_WIDTH(8)) m_if ();

    mdm_uart_loopback_fifo #(
        .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FLUSH_CHAR(8'h0D), .DROP_ON_FULL(1),
        .CNT_WIDTH(CNT_W), .LED_HOLD(LED_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if), .mode(mode),
        .clr_stats(clr_stats), .rx_count(rx_count), .tx_count(tx_count),
        .drop_count(drop_count), .overflow(overflow), .fifo_level(fifo_level), .led(led)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of stored bytes and plain integer counters.
    logic [7:0] q[$];
    int m_rx, m_tx, m_drop, m_since;
    bit m_ovf, m_held;

    function automatic logic [7:0] xf(input logic [7:0] b, input logic [1:0] m);
        if (m != 2'd1) return b;
        if (b >= "a" && b <= "z") return b - 8'd32;
        if (b >= "A" && b <= "Z") return b + 8'd32;
        return b;
    endfunction

    function automatic int eol_in_q();
        int n = 0;
        foreach (q[i]) if (q[i] == 8'h0D) n++;
        return n;
    endfunction

    function automatic bit exp_valid();
        return q.size() != 0 &&
               (mode != 2'd2 || eol_in_q() > 0 || q.size() == DEPTH || m_held);
    endfunction

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit v, pp, ph, fl;
        logic [7:0] tmp;
        if (rst) begin
            q.delete();
            m_rx = 0; m_tx = 0; m_drop = 0; m_ovf = 0; m_held = 0;
            m_since = LED_HOLD;
        end else begin
            v  = exp_valid();
            pp = v && m_if.tready;
            ph = s_if.tvalid;
            fl = (q.size() == DEPTH);
            if (pp) begin
                tmp = q.pop_front();
                m_tx = sat(m_tx);
            end
            if (ph) begin
                m_rx = sat(m_rx);
                if (mode != 2'd3) begin
                    if (!fl || pp) q.push_back(xf(s_if.tdata, mode));
                    else begin m_drop = sat(m_drop); m_ovf = 1; end
                end
            end
            m_held = v && !m_if.tready;
            if (clr_stats) begin m_rx = 0; m_tx = 0; m_drop = 0; m_ovf = 0; end
            if (ph || pp) m_since = 0;
            else if (m_since < LED_HOLD) m_since++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_tvalid", int'(m_if.tvalid), int'(exp_valid()));
            if (exp_valid()) check("m_tdata", int'(m_if.tdata), int'(q[0]));
            check("fifo_level", int'(fifo_level), q.size());
            check("rx_count", int'(rx_count), m_rx);
            check("tx_count", int'(tx_count), m_tx);
            check("drop_count", int'(drop_count), m_drop);
            check("overflow", int'(overflow), int'(m_ovf));
            check("led", int'(led), int'(m_since < LED_HOLD));
            check("s_tready", int'(s_if.tready), 1);
        end
    end

    logic [7:0] out_q[$];
    always @(negedge clk) begin
        if (!rst && m_if.tvalid && m_if.tready) out_q.push_back(m_if.tdata);
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic idle(input int n); repeat (n) tick(); endtask
    task automatic push(input logic [7:0] b);
        s_if.tvalid = 1'b1; s_if.tdata = b; tick(); s_if.tvalid = 1'b0;
    endtask
    task automatic clear(); clr_stats = 1'b1; tick(); clr_stats = 1'b0; endtask
    task automatic expect_out(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2);
        logic [7:0] e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        check({nm, "_count"}, out_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check(nm, (i < out_q.size()) ? int'(out_q[i]) : -1, int'(e[i]));
    endtask

    initial begin
        logic [7:0] d;
        int r, rdy_pct;
        rst = 1'b1; mode = 2'd0; clr_stats = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = 8'h00; m_if.tready = 1'b0;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tvalid", int'(m_if.tvalid), 0);
        check("reset_level", int'(fifo_level), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_led", int'(led), 0);
        check("reset_rx", int'(rx_count), 0);

        tick();
        m_if.tready = 1'b1; out_q.delete();
        push(8'h41); push(8'h42); push(8'h43); idle(3);
        expect_out("pass_out", 8'h41, 8'h42, 8'h43);
        check("pass_tx", int'(tx_count), 3);

        clear(); mode = 2'd1; out_q.delete();
        push("a"); push("Z"); push("5"); idle(3);
        expect_out("case_out", "A", "z", "5");
        check("case_rx", int'(rx_count), 3);

        mode = 2'd2; out_q.delete();
        push("H"); push("I"); idle(4);
        @(negedge clk);
        check("line_hold_tvalid", int'(m_if.tvalid), 0);
        check("line_hold_level", int'(fifo_level), 2);
        tick();
        push(8'h0D); idle(5);
        expect_out("line_out", "H", "I", 8'h0D);
        push("X"); idle(3);
        @(negedge clk);
        check("line_eol_zero", int'(m_if.tvalid), 0);
        tick();
        mode = 2'd0; idle(3);

        clear(); m_if.tready = 1'b0;
        for (int i = 0; i < 20; i++) push(8'h10 + 8'(i));
        @(negedge clk);
        check("ovf_level", int'(fifo_level), 16);
        check("ovf_drop", int'(drop_count), 4);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_rx", int'(rx_count), 20);
        tick();
        out_q.delete(); m_if.tready = 1'b1; idle(20);
        check("ovf_drain_count", out_q.size(), 16);
        for (int i = 0; i < 16; i++)
            check("ovf_drain", (i < out_q.size()) ? int'(out_q[i]) : -1, 16 + i);

        m_if.tready = 1'b0; push(8'h55); idle(1); mode = 2'd2; idle(3);
        @(negedge clk);
        check("bp_tvalid", int'(m_if.tvalid), 1);
        check("bp_tdata", int'(m_if.tdata), 8'h55);
        tick();
        m_if.tready = 1'b1; idle(2); mode = 2'd0;

        clear();
        @(negedge clk);
        check("clr_rx", int'(rx_count), 0);
        check("clr_drop", int'(drop_count), 0);
        check("clr_overflow", int'(overflow), 0);
        tick();
        idle(LED_HOLD + 2);
        @(negedge clk);
        check("led_off", int'(led), 0);
        tick();

        rdy_pct = 80;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rdy_pct = $urandom_range(10, 95);
            r = $urandom_range(0, 9);
            if (r < 2) d = 8'h0D;
            else if (r < 5) d = ($urandom_range(0, 1) ? 8'h41 : 8'h61) + 8'($urandom_range(0, 25));
            else d = 8'($urandom_range(0, 255));
            s_if.tvalid = ($urandom_range(0, 99) < 60);
            s_if.tdata  = d;
            m_if.tready = ($urandom_range(0, 99) < rdy_pct);
            if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
            clr_stats = ($urandom_range(0, 99) < 1);
            tick();
        end
        s_if.tvalid = 1'b0; clr_stats = 1'b0; mode = 2'd0;

        m_if.tready = 1'b0;
        push(8'h21); push(8'h22); push(8'h23);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_tvalid", int'(m_if.tvalid), 0);
        check("rst_async_level", int'(fifo_level), 0);
        @(posedge clk); #1 rst = 1'b0;
        m_if.tready = 1'b1;
        push(8'h77); idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
